// File: rtl/shake_input_arbiter.sv
// Two-requester whole-message arbiter feeding the SHAKE load stage; SHAKE_ARB_FIXED_PRIORITY_EN selects fixed priority over round-robin.
// Latency: grant one cycle after req_valid, then combinational word forwarding.
// Backpressure: ready_in is passed straight to the owner's req_ready; the other requester sees 0.
module shake_input_arbiter #(
    parameter int W        = 64,
    parameter int LEN_BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [W-1:0]    req_data0,
    input  logic [W-1:0]    req_data1,
    output logic [1:0]      req_ready,
    output logic            valid_out,
    output logic [W-1:0]    data_out,
    input  logic            ready_in,
    output logic [1:0]      grant,
    output logic            busy
);
    localparam int                LOG2W = $clog2(W);
    localparam logic [LEN_BITS:0] ONE   = (LEN_BITS+1)'(1);
    localparam logic [LEN_BITS:0] RND   = (LEN_BITS+1)'(W - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_e;

    state_e            state_q;
    logic              owner_q;
    logic [1:0]        grant_q;
    logic              busy_q;
    logic [LEN_BITS:0] remaining_q;
    logic [LEN_BITS:0] remaining_d;
    logic [LEN_BITS:0] beats;
    logic [W-1:0]      owner_dat;
    logic              xfer;
    logic              last_xfer;
    logic              pick;

    assign owner_dat = owner_q ? req_data1 : req_data0;
    assign xfer      = busy_q & req_valid[owner_q] & ready_in;

    // One extra bit keeps the round-up from wrapping at the largest length.
    assign beats       = ({1'b0, owner_dat[LEN_BITS-1:0]} + RND) >> LOG2W;
    assign remaining_d = (state_q == HEADER) ? beats : remaining_q - ONE;
    assign last_xfer   = xfer & (remaining_d == '0);

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign valid_out = busy_q & req_valid[owner_q];
    assign data_out  = busy_q ? owner_dat : '0;
    assign req_ready = (busy_q & ready_in) ? grant_q : 2'b00;

`ifdef SHAKE_ARB_FIXED_PRIORITY_EN
    assign pick = ~req_valid[0];
`else
    logic rr_ptr_q;

    // rr_ptr_q names the requester that lost the previous contest.
    assign pick = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            remaining_q <= '0;
`ifndef SHAKE_ARB_FIXED_PRIORITY_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        owner_q <= pick;
                        grant_q <= pick ? 2'b10 : 2'b01;
                        busy_q  <= 1'b1;
                        state_q <= HEADER;
                    end
                end
                HEADER, PAYLOAD: begin
                    if (xfer) begin
                        remaining_q <= remaining_d;
                        if (last_xfer) begin
                            state_q  <= IDLE;
                            grant_q  <= 2'b00;
                            busy_q   <= 1'b0;
`ifndef SHAKE_ARB_FIXED_PRIORITY_EN
                            rr_ptr_q <= ~owner_q;
`endif
                        end else begin
                            state_q <= PAYLOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shake_input_arbiter.sv
// Randomized bench for shake_input_arbiter against a message-level reference model.
module tb_shake_input_arbiter;
    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [W-1:0]  req_data0;
    logic [W-1:0]  req_data1;
    logic [1:0]    req_ready;
    logic          valid_out;
    logic [W-1:0]  data_out;
    logic          ready_in;
    logic [1:0]    grant;
    logic          busy;

    shake_input_arbiter #(.W(W), .LEN_BITS(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
        .req_data1(req_data1), .req_ready(req_ready), .valid_out(valid_out),
        .data_out(data_out), .ready_in(ready_in), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: who owns the load stage and how many words remain.
    int      m_owner = -1;
    bit      m_in_hdr;
    longint  m_left;
    int      m_ptr = 0;

    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    int      xfers[2];
    int      glog[$];
    int      seq[2];
    int      totw;
    bit      saw_rdy0;
    int      pvalid;
    int      pready;

    task automatic model_step();
        logic [63:0] wd;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            if (req_valid != 2'b00) begin
`ifdef SHAKE_ARB_FIXED_PRIORITY_EN
                m_owner = req_valid[0] ? 0 : 1;
`else
                m_owner = (req_valid == 2'b11) ? m_ptr : (req_valid[0] ? 0 : 1);
`endif
                m_in_hdr = 1'b1;
                glog.push_back(m_owner);
            end
        end else if (req_valid[m_owner] && ready_in) begin
            wd = (m_owner == 0) ? req_data0 : req_data1;
            xfers[m_owner]++;
            if (m_owner == 0 && wq0.size() > 0) void'(wq0.pop_front());
            if (m_owner == 1 && wq1.size() > 0) void'(wq1.pop_front());
            if (m_in_hdr) begin
                m_left   = ({32'd0, wd[31:0]} + W - 1) / W;
                m_in_hdr = 1'b0;
            end else begin
                m_left--;
            end
            if (m_left == 0) begin
                m_ptr   = 1 - m_owner;
                m_owner = -1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        ready_in = 1'b0;
        tick();
        rst = 1'b0;
        wq0.delete();
        wq1.delete();
        glog.delete();
        xfers[0] = 0; xfers[1] = 0;
        seq[0] = 0; seq[1] = 0;
        totw = 0;
        saw_rdy0 = 1'b0;
    endtask

    task automatic add_msg(input int r, input int len);
        logic [63:0] w;
        int n;
        n = (len + W - 1) / W;
        w = {4'(r), 28'(seq[r]), 32'(len)};
        if (r == 0) wq0.push_back(w); else wq1.push_back(w);
        for (int k = 0; k < n; k++) begin
            w = {4'(r), 28'(seq[r]), $urandom};
            if (r == 0) wq0.push_back(w); else wq1.push_back(w);
        end
        seq[r]++;
        totw += n + 1;
    endtask

    // Drives both request streams and compares every output, every cycle, with the model.
    task automatic run_traffic(input int budget);
        int cyc;
        logic [1:0]  eg;
        logic [1:0]  er;
        logic [63:0] ed;
        logic [69:0] exp_v;
        logic [69:0] act_v;
        cyc = 0;
        while ((wq0.size() > 0 || wq1.size() > 0 || m_owner >= 0) && cyc < budget) begin
            req_valid[0] = (wq0.size() > 0) && ($urandom_range(99) < pvalid);
            req_valid[1] = (wq1.size() > 0) && ($urandom_range(99) < pvalid);
            req_data0 = (wq0.size() > 0) ? wq0[0] : {$urandom, $urandom};
            req_data1 = (wq1.size() > 0) ? wq1[0] : {$urandom, $urandom};
            ready_in  = ($urandom_range(99) < pready);
            #1;
            eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
            er = (m_owner >= 0 && ready_in) ? eg : 2'b00;
            ed = (m_owner < 0) ? 64'd0 : ((m_owner == 0) ? req_data0 : req_data1);
            exp_v = {eg, (m_owner >= 0), ((m_owner >= 0) ? req_valid[m_owner] : 1'b0), er, ed};
            act_v = {grant, busy, valid_out, req_ready, data_out};
            n_total++;
            if (act_v !== exp_v)
                $display("FAIL cycle_outputs t=%0t got=%h want=%h (grant,busy,valid,ready,data)", $time, act_v, exp_v);
            else
                n_pass++;
            if (req_ready[0]) saw_rdy0 = 1'b1;
            tick();
            cyc++;
        end
        req_valid = 2'b00;
        n_total++;
        if (cyc >= budget) $display("FAIL traffic_timeout got=%0d cycles want<%0d", cyc, budget);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        ready_in = 1'b1;
        req_data0 = 64'd64;
        req_data1 = 64'd64;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            n_total++;
            if ({grant, valid_out, req_ready} !== 5'b0)
                $display("FAIL reset_outputs got=%b want=00000", {grant, valid_out, req_ready});
            else
                n_pass++;
        end
        rst = 1'b0;
        tick();
        #1;
        n_total++;
        if (grant !== 2'b01) $display("FAIL reset_first_grant got=%b want=01", grant);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        pvalid = 100; pready = 100;
        add_msg(1, 200);
        run_traffic(100);
        n_total++;
        if (xfers[1] !== 5 || xfers[0] !== 0)
            $display("FAIL single_words got=%0d/%0d want=5/0", xfers[1], xfers[0]);
        else n_pass++;
        n_total++;
        if (saw_rdy0 !== 1'b0) $display("FAIL single_rdy0 got=%b want=0", saw_rdy0);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL single_busy_end got=%b want=0", busy);
        else n_pass++;
    endtask

    task automatic test_contention();
        int exp_g[4];
`ifdef SHAKE_ARB_FIXED_PRIORITY_EN
        exp_g = '{0, 0, 1, 1};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        do_reset();
        pvalid = 100; pready = 100;
        for (int k = 0; k < 2; k++) begin
            add_msg(0, 64);
            add_msg(1, 64);
        end
        run_traffic(100);
        n_total++;
        if (glog.size() !== 4) $display("FAIL contention_count got=%0d want=4", glog.size());
        else n_pass++;
        for (int k = 0; k < 4 && k < glog.size(); k++) begin
            n_total++;
            if (glog[k] !== exp_g[k]) $display("FAIL contention_order[%0d] got=%0d want=%0d", k, glog[k], exp_g[k]);
            else n_pass++;
        end
    endtask

    task automatic test_boundaries();
        do_reset();
        pvalid = 100; pready = 100;
        add_msg(0, 0);
        add_msg(0, 1);
        add_msg(0, 64);
        add_msg(0, 65);
        run_traffic(200);
        n_total++;
        if (xfers[0] !== 8 || glog.size() !== 4)
            $display("FAIL boundary_words got=%0d msgs=%0d want=8 msgs=4", xfers[0], glog.size());
        else n_pass++;

        do_reset();
        req_valid = 2'b01;
        req_data0 = {32'd0, 32'hFFFF_FFFF};
        req_data1 = 64'd0;
        ready_in  = 1'b1;
        tick();
        tick();
        n_total++;
        if (dut.remaining_q !== 33'h0_0400_0000)
            $display("FAIL max_len_remaining got=%h want=%h", dut.remaining_q, 33'h0_0400_0000);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            req_data0 = {$urandom, $urandom};
            tick();
        end
        #1;
        n_total++;
        if (dut.remaining_q !== 33'h0_03FF_FFFD || grant !== 2'b01)
            $display("FAIL max_len_count got=%h/%b want=%h/01", dut.remaining_q, grant, 33'h0_03FF_FFFD);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        #1;
        n_total++;
        if ({grant, busy, valid_out, req_ready} !== 6'b0)
            $display("FAIL reset_mid got=%b want=000000", {grant, busy, valid_out, req_ready});
        else n_pass++;
        rst = 1'b0;
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_stalls();
        do_reset();
        pvalid = 70; pready = 50;
        for (int k = 0; k < 4; k++) begin
            add_msg(0, $urandom_range(300));
            add_msg(1, $urandom_range(300));
        end
        run_traffic(5000);
        n_total++;
        if (xfers[0] + xfers[1] !== totw || wq0.size() != 0 || wq1.size() != 0)
            $display("FAIL stall_words got=%0d want=%0d", xfers[0] + xfers[1], totw);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        req_data0 = '0;
        req_data1 = '0;
        ready_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_boundaries();
        test_reset_mid();
        test_stalls();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
